// File: rtl/dds_pkg.sv
// Shared types and helpers for the DDS sweep synthesiser.
//   state_t   : control FSM states (S_IDLE, S_RUN, S_SWEEP, S_HOLD)
//   lut_entry : elaboration-time value of one quarter-wave ROM entry
//   fold_idx  : maps a full-wave address onto a quarter-wave ROM index
//   apply_sign: negates a ROM magnitude in the lower half-wave
// Optional feature macro used by the files that import this package:
//   DDS_COS_OUT_EN (adds the quadrature cosine path).
package dds_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_SWEEP = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  localparam real PI = 3.14159265358979323846;

  // Odd Taylor series of sin(x) for x in [0, pi/2]; 12 terms leave an error
  // far below half an output LSB, so rounding matches an ideal sine.
  function automatic real sin_poly(input real x);
    real term;
    real sum;
    term = x;
    sum  = x;
    for (int i = 1; i <= 12; i++) begin
      term = -term * x * x / real'((2 * i) * (2 * i + 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  // Half-LSB phase offset: entry k samples the middle of its phase slot, so
  // the quarter wave has no duplicated 0 or full-scale endpoints.
  function automatic int lut_entry(input int k, input int addr_w, input int out_w);
    real fs;
    real x;
    fs = real'((1 << (out_w - 1)) - 1);
    x  = (PI / 2.0) * (real'(k) + 0.5) / real'(1 << (addr_w - 2));
    return $rtoi(fs * sin_poly(x) + 0.5);
  endfunction

  // Quadrants 1 and 3 run the quarter wave backwards (bitwise inverse index).
  function automatic int unsigned fold_idx(input int unsigned addr, input int addr_w);
    int unsigned mask;
    int unsigned lo;
    mask = (32'd1 << (addr_w - 2)) - 32'd1;
    lo   = addr & mask;
    return (((addr >> (addr_w - 2)) & 32'd1) != 32'd0) ? (lo ^ mask) : lo;
  endfunction

  // Quadrants 2 and 3 (address MSB set) are the negative half-wave.
  function automatic int apply_sign(input int mag, input logic neg);
    return neg ? -mag : mag;
  endfunction

endpackage

// File: rtl/dds_quarter_lut.sv
// Quarter-wave sine ROM with registered read.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (clears read regs)
//   en_i       : read enable; output registers hold when low
//   idx_a_i    : quarter-wave index, port A (sine)
//   mag_a_o    : unsigned magnitude, port A, one cycle after idx_a_i
//   idx_b_i    : quarter-wave index, port B (cosine)  [DDS_COS_OUT_EN]
//   mag_b_o    : unsigned magnitude, port B           [DDS_COS_OUT_EN]
// Macro DDS_COS_OUT_EN adds the second read port.
module dds_quarter_lut
  import dds_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int OUT_W  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic [ADDR_W-3:0] idx_a_i,
  output logic [OUT_W-2:0]  mag_a_o
`ifdef DDS_COS_OUT_EN
  ,
  input  logic [ADDR_W-3:0] idx_b_i,
  output logic [OUT_W-2:0]  mag_b_o
`endif
);

  localparam int N     = 1 << (ADDR_W - 2);
  localparam int MAG_W = OUT_W - 1;

  logic [MAG_W-1:0] rom [N];

  for (genvar k = 0; k < N; k++) begin : g_rom
    localparam int V = lut_entry(k, ADDR_W, OUT_W);
    assign rom[k] = MAG_W'(V);
  end

  logic [MAG_W-1:0] mag_a_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mag_a_q <= '0;
    end else if (en_i) begin
      mag_a_q <= rom[idx_a_i];
    end
  end

  assign mag_a_o = mag_a_q;

`ifdef DDS_COS_OUT_EN
  logic [MAG_W-1:0] mag_b_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mag_b_q <= '0;
    end else if (en_i) begin
      mag_b_q <= rom[idx_b_i];
    end
  end

  assign mag_b_o = mag_b_q;
`endif

endmodule

// File: rtl/dds_sweep_synth.sv
// DDS with fixed-tone and linear frequency-sweep modes.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   cfg_valid/ready   : config handshake (see below)
//   cfg_mode          : 0 fixed tone, 1 sweep
//   cfg_ftw_start/stop/step, cfg_dwell, cfg_phase_off : config fields
//   stop              : abort back to idle
//   sine_out          : signed sine sample (3 cycles after the accumulator)
//   cos_out           : signed cosine sample      [DDS_COS_OUT_EN]
//   out_valid         : sample valid
//   ftw_cur           : tuning word currently accumulated
//   sweep_done        : one-cycle pulse when ftw_cur lands on the stop word
//   busy              : not idle
//   dbg_state         : current FSM state (state_t encoding)
// Macro DDS_COS_OUT_EN adds cos_out and the second ROM read port.
//
// Handshake: cfg_ready is high exactly in S_IDLE; a config transfers on a
// rising clk edge where cfg_valid && cfg_ready. cfg_valid is don't-care while
// busy, and all cfg_* fields are latched on transfer so they may change after.
module dds_sweep_synth
  import dds_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 10,
  parameter int OUT_W   = 12,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic               cfg_mode,
  input  logic [PHASE_W-1:0] cfg_ftw_start,
  input  logic [PHASE_W-1:0] cfg_ftw_stop,
  input  logic [PHASE_W-1:0] cfg_ftw_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [PHASE_W-1:0] cfg_phase_off,
  input  logic               stop,
  output logic [OUT_W-1:0]   sine_out,
`ifdef DDS_COS_OUT_EN
  output logic [OUT_W-1:0]   cos_out,
`endif
  output logic               out_valid,
  output logic [PHASE_W-1:0] ftw_cur,
  output logic               sweep_done,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int MAG_W = OUT_W - 1;

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [PHASE_W-1:0] ftw_cur_q, ftw_cur_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic               sweep_done_q, sweep_done_d;

  logic [PHASE_W-1:0] ftw_stop_q, ftw_step_q, phase_off_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               dir_up_q;

  logic               accept;
  logic [PHASE_W:0]   nxt_up, nxt_dn;
  logic               hit;

  assign cfg_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;
  assign accept    = cfg_valid && cfg_ready;

  // ---------------- control FSM ----------------
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    ftw_cur_d    = ftw_cur_q;
    dwell_cnt_d  = dwell_cnt_q;
    sweep_done_d = 1'b0;

    // One extra bit catches wrap-around in either direction as "passed stop".
    nxt_up = {1'b0, ftw_cur_q} + {1'b0, ftw_step_q};
    nxt_dn = {1'b0, ftw_cur_q} - {1'b0, ftw_step_q};
    if (ftw_step_q == '0) begin
      hit = 1'b1;
    end else if (dir_up_q) begin
      hit = (nxt_up >= {1'b0, ftw_stop_q});
    end else begin
      hit = nxt_dn[PHASE_W] || (nxt_dn[PHASE_W-1:0] <= ftw_stop_q);
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          acc_d       = '0;
          ftw_cur_d   = cfg_ftw_start;
          dwell_cnt_d = '0;
          state_d     = cfg_mode ? S_SWEEP : S_RUN;
        end
      end
      S_RUN, S_HOLD: begin
        acc_d = acc_q + ftw_cur_q;
        if (stop) state_d = S_IDLE;
      end
      S_SWEEP: begin
        acc_d = acc_q + ftw_cur_q;
        // stop has priority: an expiry in the same cycle is discarded.
        if (stop) begin
          state_d = S_IDLE;
        end else if (dwell_cnt_q == dwell_q) begin
          dwell_cnt_d = '0;
          if (hit) begin
            ftw_cur_d    = ftw_stop_q;
            sweep_done_d = 1'b1;
            state_d      = S_HOLD;
          end else begin
            ftw_cur_d = dir_up_q ? nxt_up[PHASE_W-1:0] : nxt_dn[PHASE_W-1:0];
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      ftw_cur_q    <= '0;
      dwell_cnt_q  <= '0;
      sweep_done_q <= 1'b0;
      ftw_stop_q   <= '0;
      ftw_step_q   <= '0;
      phase_off_q  <= '0;
      dwell_q      <= '0;
      dir_up_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      ftw_cur_q    <= ftw_cur_d;
      dwell_cnt_q  <= dwell_cnt_d;
      sweep_done_q <= sweep_done_d;
      if (accept) begin
        ftw_stop_q  <= cfg_ftw_stop;
        ftw_step_q  <= cfg_ftw_step;
        phase_off_q <= cfg_phase_off;
        dwell_q     <= cfg_dwell;
        dir_up_q    <= (cfg_ftw_start <= cfg_ftw_stop);
      end
    end
  end

  assign ftw_cur    = ftw_cur_q;
  assign sweep_done = sweep_done_q;

  // ---------------- sample pipeline ----------------
  // Each stage only loads while the sample it carries is live, so after a
  // stop the output freezes on the last valid sample rather than drifting.
  logic [2:0]        run_q;
  logic [ADDR_W-1:0] addr_q;
  logic [IDX_W-1:0]  idx_s;
  logic [MAG_W-1:0]  mag_s;
  logic              neg_s_q;
  logic [OUT_W-1:0]  sine_q;

  assign idx_s = IDX_W'(fold_idx(32'(addr_q), ADDR_W));

`ifdef DDS_COS_OUT_EN
  localparam int QTR = 1 << IDX_W;
  logic [ADDR_W-1:0] addr_c;
  logic [IDX_W-1:0]  idx_c;
  logic [MAG_W-1:0]  mag_c;
  logic              neg_c_q;
  logic [OUT_W-1:0]  cos_q;

  // cos(x) = sin(x + quarter turn): same ROM, address one quadrant ahead.
  assign addr_c = addr_q + ADDR_W'(QTR);
  assign idx_c  = IDX_W'(fold_idx(32'(addr_c), ADDR_W));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q   <= '0;
      addr_q  <= '0;
      neg_s_q <= 1'b0;
      sine_q  <= '0;
`ifdef DDS_COS_OUT_EN
      neg_c_q <= 1'b0;
      cos_q   <= '0;
`endif
    end else begin
      run_q <= {run_q[1:0], busy};
      if (busy) begin
        addr_q <= ADDR_W'((acc_q + phase_off_q) >> (PHASE_W - ADDR_W));
      end
      if (run_q[0]) begin
        neg_s_q <= addr_q[ADDR_W-1];
`ifdef DDS_COS_OUT_EN
        neg_c_q <= addr_c[ADDR_W-1];
`endif
      end
      if (run_q[1]) begin
        sine_q <= OUT_W'(apply_sign(int'(mag_s), neg_s_q));
`ifdef DDS_COS_OUT_EN
        cos_q  <= OUT_W'(apply_sign(int'(mag_c), neg_c_q));
`endif
      end
    end
  end

  dds_quarter_lut #(
    .ADDR_W(ADDR_W),
    .OUT_W (OUT_W)
  ) u_lut (
    .clk    (clk),
    .reset  (reset),
    .en_i   (run_q[0]),
    .idx_a_i(idx_s),
    .mag_a_o(mag_s)
`ifdef DDS_COS_OUT_EN
    ,
    .idx_b_i(idx_c),
    .mag_b_o(mag_c)
`endif
  );

  assign sine_out  = sine_q;
  assign out_valid = run_q[2];
`ifdef DDS_COS_OUT_EN
  assign cos_out   = cos_q;
`endif

endmodule

// File: tb/tb_dds_sweep_synth.sv
// Self-checking bench for dds_sweep_synth (default parameters).
// Reference: ideal full-wave sine with half-slot phase offset, and a
// closed-form sweep schedule (step count = cycle / (dwell+1), clamped).
module tb_dds_sweep_synth;

  localparam int  PHASE_W = 32;
  localparam int  ADDR_W  = 10;
  localparam int  OUT_W   = 12;
  localparam int  DWELL_W = 16;
  localparam real M_PI    = 3.14159265358979323846;

  typedef struct {
    bit          mode;
    logic [31:0] start;
    logic [31:0] stopw;
    logic [31:0] step;
    int          dwell;
    logic [31:0] off;
    int          stop_at;   // cycle index on which stop is asserted
    int          chk_n;     // sample index with a hand-computed value (-1: none)
    int          chk_val;
    int          exp_done;  // cycle of sweep_done pulse (-1: none)
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic               cfg_valid, cfg_ready, cfg_mode, stop;
  logic [PHASE_W-1:0] cfg_ftw_start, cfg_ftw_stop, cfg_ftw_step, cfg_phase_off;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [OUT_W-1:0]   sine_out;
`ifdef DDS_COS_OUT_EN
  logic [OUT_W-1:0]   cos_out;
`endif
  logic               out_valid, sweep_done, busy;
  logic [PHASE_W-1:0] ftw_cur;
  logic [1:0]         dbg_state;

  dds_sweep_synth #(
    .PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .OUT_W(OUT_W), .DWELL_W(DWELL_W)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode),
    .cfg_ftw_start(cfg_ftw_start), .cfg_ftw_stop(cfg_ftw_stop),
    .cfg_ftw_step(cfg_ftw_step), .cfg_dwell(cfg_dwell),
    .cfg_phase_off(cfg_phase_off), .stop(stop),
    .sine_out(sine_out),
`ifdef DDS_COS_OUT_EN
    .cos_out(cos_out),
`endif
    .out_valid(out_valid), .ftw_cur(ftw_cur), .sweep_done(sweep_done),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int n, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s n=%0d got=%0d exp=%0d", name, n, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int ref_sample(input logic [31:0] phase);
    int  a;
    real v;
    a = int'(phase >> (PHASE_W - ADDR_W));
    v = real'((1 << (OUT_W - 1)) - 1) * $sin(2.0 * M_PI * (real'(a) + 0.5) / real'(1 << ADDR_W));
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  function automatic logic [31:0] ref_ftw(input vec_t c, input int n, output bit clamped);
    longint v, k;
    clamped = 1'b0;
    if (!c.mode) return c.start;
    k = longint'(n / (c.dwell + 1));
    if (k == 0) return c.start;
    if (c.start <= c.stopw) begin
      v = longint'(c.start) + longint'(c.step) * k;
      clamped = (c.step == 0) || (v >= longint'(c.stopw));
    end else begin
      v = longint'(c.start) - longint'(c.step) * k;
      clamped = (c.step == 0) || (v <= longint'(c.stopw));
    end
    return clamped ? c.stopw : v[31:0];
  endfunction

  function automatic vec_t mk(input bit mode, input logic [31:0] start, input logic [31:0] stopw,
                              input logic [31:0] step, input int dwell, input logic [31:0] off,
                              input int stop_at, input int chk_n, input int chk_val, input int exp_done);
    vec_t c;
    c.mode = mode; c.start = start; c.stopw = stopw; c.step = step; c.dwell = dwell;
    c.off = off; c.stop_at = stop_at; c.chk_n = chk_n; c.chk_val = chk_val; c.exp_done = exp_done;
    return c;
  endfunction

  // ---------------- driver: one configuration, checked every cycle ----------------
  task automatic run_scenario(input vec_t c, input bit use_tbl);
    logic [31:0] acc_m [256];
    logic [31:0] ftw_m [256];
    int          done_m, first_done, n_done, w, m, s, exp_st;
    bit          cl;

    w = 0;
    while (!cfg_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("cfg_ready_wait", w, cfg_ready, 1);

    done_m   = -1;
    acc_m[0] = '0;
    for (int n = 0; n <= c.stop_at; n++) begin
      ftw_m[n] = ref_ftw(c, n, cl);
      if (cl && done_m < 0) done_m = n;
      if (n < c.stop_at) acc_m[n+1] = acc_m[n] + ftw_m[n];
    end

    cfg_valid     = 1'b1;
    cfg_mode      = c.mode;
    cfg_ftw_start = c.start;
    cfg_ftw_stop  = c.stopw;
    cfg_ftw_step  = c.step;
    cfg_dwell     = DWELL_W'(c.dwell);
    cfg_phase_off = c.off;
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;

    first_done = -1;
    n_done     = 0;
    for (int n = 0; n <= c.stop_at + 5; n++) begin
      m = (n <= c.stop_at) ? n : c.stop_at;
      if (n > c.stop_at) exp_st = 0;
      else if (!c.mode) exp_st = 1;
      else if (done_m >= 0 && n >= done_m) exp_st = 3;
      else exp_st = 2;
      check("busy", n, busy, longint'(n <= c.stop_at));
      check("cfg_ready", n, cfg_ready, longint'(n > c.stop_at));
      check("state", n, dbg_state, exp_st);
      check("ftw_cur", n, ftw_cur, ftw_m[m]);
      check("sweep_done", n, sweep_done, longint'(n == done_m && n <= c.stop_at));
      check("out_valid", n, out_valid, longint'(n >= 3 && n <= c.stop_at + 3));
      if (n >= 3) begin
        s = (n - 3 <= c.stop_at) ? n - 3 : c.stop_at;
        check("sine_out", n, $signed(sine_out), ref_sample(acc_m[s] + c.off));
`ifdef DDS_COS_OUT_EN
        check("cos_out", n, $signed(cos_out), ref_sample(acc_m[s] + c.off + 32'h4000_0000));
`endif
      end
      if (use_tbl && c.chk_n >= 0 && n - 3 == c.chk_n)
        check("tbl_sample", n, $signed(sine_out), c.chk_val);
      if (sweep_done) begin
        n_done++;
        if (first_done < 0) first_done = n;
      end
      // A config offered while busy must be ignored; the fields change too.
      if (n == 2) begin
        cfg_valid     = 1'b1;
        cfg_mode      = ~c.mode;
        cfg_ftw_start = $urandom;
        cfg_ftw_stop  = $urandom;
        cfg_ftw_step  = $urandom;
        cfg_dwell     = DWELL_W'($urandom);
        cfg_phase_off = $urandom;
      end
      if (n == 3) cfg_valid = 1'b0;
      stop = (n == c.stop_at);
      @(negedge clk);
    end

    if (use_tbl) begin
      check("tbl_first_done", c.stop_at, first_done, c.exp_done);
      check("tbl_done_count", c.stop_at, n_done, longint'(c.exp_done >= 0));
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cfg_ready"}, 0, cfg_ready, 1);
    check({tag, "_busy"}, 0, busy, 0);
    check({tag, "_out_valid"}, 0, out_valid, 0);
    check({tag, "_sine_out"}, 0, sine_out, 0);
    check({tag, "_ftw_cur"}, 0, ftw_cur, 0);
    check({tag, "_sweep_done"}, 0, sweep_done, 0);
    check({tag, "_state"}, 0, dbg_state, 0);
  endtask

  // ---------------- main sequence ----------------
  vec_t tbl [10];
  vec_t rc;

  initial begin
    tbl[0] = mk(0, 32'h0400_0000, 32'h0, 32'h0, 0, 32'h0, 60, 0, 6, -1);
    tbl[1] = mk(0, 32'h0400_0000, 32'h0, 32'h0, 0, 32'h0, 60, 16, 2047, -1);
    tbl[2] = mk(0, 32'h0400_0000, 32'h0, 32'h0, 0, 32'h0, 60, 48, -2047, -1);
    tbl[3] = mk(0, 32'h0400_0000, 32'h0, 32'h0, 0, 32'h4000_0000, 20, 0, 2047, -1);
    tbl[4] = mk(1, 32'h0100_0000, 32'h0100_0400, 32'h100, 9, 32'h0, 60, 0, 6, 40);
    tbl[5] = mk(1, 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h200, 0, 32'h0, 20, 0, 6, 1);
    tbl[6] = mk(1, 32'h0100_0000, 32'h0100_0400, 32'h100, 9, 32'h0, 39, -1, 0, -1);
    tbl[7] = mk(1, 32'h0010_0000, 32'h000F_F000, 32'h800, 2, 32'h0, 20, -1, 0, 6);
    tbl[8] = mk(1, 32'h0200_0000, 32'h0300_0000, 32'h0, 3, 32'h0, 20, -1, 0, 4);
    tbl[9] = mk(1, 32'h0000_0100, 32'h0, 32'h300, 0, 32'h0, 20, -1, 0, 1);

    reset = 1'b1;
    cfg_valid = 1'b0; cfg_mode = 1'b0; stop = 1'b0;
    cfg_ftw_start = '0; cfg_ftw_stop = '0; cfg_ftw_step = '0;
    cfg_dwell = '0; cfg_phase_off = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_scenario(tbl[i], 1'b1);

    // Reset in the middle of a sweep: everything back to reset values at once.
    cfg_valid = 1'b1; cfg_mode = 1'b1;
    cfg_ftw_start = 32'h0100_0000; cfg_ftw_stop = 32'h0100_0400;
    cfg_ftw_step = 32'h100; cfg_dwell = 16'd3; cfg_phase_off = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_sweep_busy", 9, busy, 1);
    reset = 1'b1;
    #1;
    check_reset_values("async_reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("after_reset");

    for (int i = 0; i < 8; i++) begin
      rc.mode    = 1'($urandom_range(0, 1));
      rc.start   = $urandom;
      if (i == 7) rc.start = 32'hFFFF_F000 | 32'($urandom_range(0, 32'hFFF));
      rc.stopw   = ($urandom_range(0, 1) == 1) ? rc.start + 32'($urandom_range(0, 32'h2_0000))
                                               : rc.start - 32'($urandom_range(0, 32'h2_0000));
      rc.step    = ($urandom_range(0, 5) == 0) ? 32'h0 : 32'($urandom_range(1, 32'h4000));
      rc.dwell   = int'($urandom_range(0, 4));
      rc.off     = $urandom;
      rc.stop_at = int'($urandom_range(8, 120));
      rc.chk_n   = -1;
      rc.chk_val = 0;
      rc.exp_done = -1;
      run_scenario(rc, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog n=0 got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
